// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream instruction handshake and downstream ALU issue bus for alu_issue.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            valid_i;
    logic            ready_o;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic            funct7b5_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [3:0]      ALU_OP_o;
    logic [XLEN-1:0] ALU_RS1_o;
    logic [XLEN-1:0] ALU_RS2_o;
    logic            branch_o;
    logic            br_inv_o;
    logic            illegal_o;
    modport slave (
        input  valid_i, opcode_i, funct3_i, funct7b5_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
               flush_i, ready_i,
        output ready_o, valid_o, ALU_OP_o, ALU_RS1_o, ALU_RS2_o, branch_o, br_inv_o, illegal_o
    );
    modport master (
        output valid_i, opcode_i, funct3_i, funct7b5_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
               flush_i, ready_i,
        input  ready_o, valid_o, ALU_OP_o, ALU_RS1_o, ALU_RS2_o, branch_o, br_inv_o, illegal_o
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: registered RV32I issue stage translating opcode/funct into ALU op and operands.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a registered ready_o.
module alu_issue #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_issue_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_SUM = 4'b0010, OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1110, OP_SLTU = 4'b1111, OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101, OP_SRA = 4'b0111, OP_XOR = 4'b1000, OP_EQUAL = 4'b0011;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            branch;
        logic            br_inv;
        logic            illegal;
    } entry_t;

    entry_t     dec, main_d, main_q;
    logic       valid_d, valid_q, legal, shift, accept;
    logic [3:0] arith_op;

    assign shift = bus.funct3_i[1:0] == 2'b01;

    always_comb begin
        arith_op = OP_AND;
        case (bus.funct3_i)
            3'b000: arith_op = bus.funct7b5_i ? OP_SUB : OP_SUM;
            3'b001: arith_op = OP_SLL;
            3'b010: arith_op = OP_SLT;
            3'b011: arith_op = OP_SLTU;
            3'b100: arith_op = OP_XOR;
            3'b101: arith_op = bus.funct7b5_i ? OP_SRA : OP_SRL;
            3'b110: arith_op = OP_OR;
            default: arith_op = OP_AND;
        endcase
    end

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (bus.opcode_i)
            OPC_OP: begin
                dec.op = arith_op;
                dec.a  = bus.rs1_data_i;
                dec.b  = shift ? {{(XLEN-5){1'b0}}, bus.rs2_data_i[4:0]} : bus.rs2_data_i;
                legal  = !bus.funct7b5_i || bus.funct3_i inside {3'b000, 3'b101};
            end
            OPC_OPIMM: begin
                dec.op = (bus.funct3_i == 3'b000) ? OP_SUM : arith_op;
                dec.a  = bus.rs1_data_i;
                dec.b  = shift ? {{(XLEN-5){1'b0}}, bus.imm_i[4:0]} : bus.imm_i;
                legal  = !(bus.funct7b5_i && bus.funct3_i == 3'b001);
            end
            OPC_LUI: begin
                dec.op = OP_SUM;
                dec.b  = bus.imm_i;
            end
            OPC_AUIPC: begin
                dec.op = OP_SUM;
                dec.a  = bus.pc_i;
                dec.b  = bus.imm_i;
            end
            OPC_JAL, OPC_JALR: begin
                dec.op = OP_SUM;
                dec.a  = bus.pc_i;
                dec.b  = XLEN'(4);
            end
            OPC_LOAD, OPC_STORE: begin
                dec.op = OP_SUM;
                dec.a  = bus.rs1_data_i;
                dec.b  = bus.imm_i;
            end
            OPC_BRANCH: begin
                // 1xx maps to GE/GEU/SLT/SLTU: bit1 selects unsigned, bit0 inverts to GE
                dec.op     = bus.funct3_i[2] ? {2'b11, !bus.funct3_i[0], bus.funct3_i[1]} : OP_EQUAL;
                dec.a      = bus.rs1_data_i;
                dec.b      = bus.rs2_data_i;
                dec.branch = 1'b1;
                dec.br_inv = bus.funct3_i == 3'b001;
                legal      = bus.funct3_i[2:1] != 2'b01;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_d, skid_q;
    logic   skid_v_d, skid_v_q, load_main;

    assign bus.ready_o = !skid_v_q;
    assign accept      = bus.valid_i && !skid_v_q;
    assign load_main   = !valid_q || bus.ready_i;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        valid_d  = valid_q;
        skid_v_d = skid_v_q;
        if (bus.flush_i) begin
            valid_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (load_main) begin
            main_d   = skid_v_q ? skid_q : (accept ? dec : main_q);
            valid_d  = skid_v_q || accept;
            skid_v_d = 1'b0;
        end else if (accept) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    assign bus.ready_o = !valid_q || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;

    always_comb begin
        main_d  = accept ? dec : main_q;
        valid_d = bus.flush_i ? 1'b0 : (accept ? 1'b1 : (valid_q && !bus.ready_i));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            main_q  <= main_d;
            valid_q <= valid_d;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.ALU_OP_o  = main_q.op;
    assign bus.ALU_RS1_o = main_q.a;
    assign bus.ALU_RS2_o = main_q.b;
    assign bus.branch_o  = main_q.branch;
    assign bus.br_inv_o  = main_q.br_inv;
    assign bus.illegal_o = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue (either ALU_ISSUE_SKID_EN build).
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   base;
    logic [31:0] oq_a[$];
    logic [31:0] oq_b[$];

    alu_issue_if #(.XLEN(32)) bus ();
    alu_issue #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.valid_i && bus.ready_o) hs_cnt <= hs_cnt + 1;
        if (rst_n && bus.valid_o && bus.ready_i) begin
            oq_a.push_back(bus.ALU_RS1_o);
            oq_b.push_back(bus.ALU_RS2_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        bus.valid_i    = 1'b1;
        bus.opcode_i   = opc;
        bus.funct3_i   = f3;
        bus.funct7b5_i = b5;
        bus.rs1_data_i = rs1;
        bus.rs2_data_i = rs2;
        bus.imm_i      = imm;
        bus.pc_i       = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        drive(7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.valid_i = 1'b0;
        repeat (2) tick;
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_op", bus.ALU_OP_o, 0);
        chk("rst_a", bus.ALU_RS1_o, 0);
        chk("rst_b", bus.ALU_RS2_o, 0);
        chk("rst_branch", bus.branch_o, 0);
        chk("rst_brinv", bus.br_inv_o, 0);
        chk("rst_illegal", bus.illegal_o, 0);
        rst_n = 1'b1;
        bus.ready_i = 1'b1;

        drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        tick;
        chk("add_valid", bus.valid_o, 1);
        chk("add_op", bus.ALU_OP_o, 4'b0010);
        chk("add_a", bus.ALU_RS1_o, 5);
        chk("add_b", bus.ALU_RS2_o, 7);
        drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 32'h0);
        tick;
        chk("sub_op", bus.ALU_OP_o, 4'b1010);
        drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0423, 32'h0);
        tick;
        chk("srai_op", bus.ALU_OP_o, 4'b0111);
        chk("srai_a", bus.ALU_RS1_o, 32'h8000_0000);
        chk("srai_b", bus.ALU_RS2_o, 32'h0000_0003);
        drive(7'b0010011, 3'b001, 1'b0, 32'h1, 32'h0, 32'h0000_0025, 32'h0);
        tick;
        chk("slli_op", bus.ALU_OP_o, 4'b0100);
        chk("slli_b", bus.ALU_RS2_o, 32'h5);
        drive(7'b0010011, 3'b000, 1'b1, 32'h1, 32'h0, 32'hFFFF_FC00, 32'h0);
        tick;
        chk("addi_op", bus.ALU_OP_o, 4'b0010);
        chk("addi_b", bus.ALU_RS2_o, 32'hFFFF_FC00);
        drive(7'b0110011, 3'b111, 1'b1, 32'h6, 32'h3, 32'h0, 32'h0);
        tick;
        chk("badf7_illegal", bus.illegal_o, 1);
        chk("badf7_op", bus.ALU_OP_o, 0);
        drive(7'b1100011, 3'b001, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
        tick;
        chk("bne_op", bus.ALU_OP_o, 4'b0011);
        chk("bne_branch", bus.branch_o, 1);
        chk("bne_brinv", bus.br_inv_o, 1);
        chk("bne_a", bus.ALU_RS1_o, 3);
        drive(7'b1100011, 3'b111, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0);
        tick;
        chk("bgeu_op", bus.ALU_OP_o, 4'b1101);
        chk("bgeu_brinv", bus.br_inv_o, 0);
        drive(7'b1100011, 3'b010, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0);
        tick;
        chk("badbr_illegal", bus.illegal_o, 1);
        chk("badbr_op", bus.ALU_OP_o, 0);
        chk("badbr_a", bus.ALU_RS1_o, 0);
        chk("badbr_b", bus.ALU_RS2_o, 0);
        chk("badbr_branch", bus.branch_o, 0);
        chk("badbr_valid", bus.valid_o, 1);
        drive(7'b0110111, 3'b000, 1'b0, 32'hDEAD, 32'h0, 32'h1234_5000, 32'h0);
        tick;
        chk("lui_op", bus.ALU_OP_o, 4'b0010);
        chk("lui_a", bus.ALU_RS1_o, 0);
        chk("lui_b", bus.ALU_RS2_o, 32'h1234_5000);
        chk("lui_illegal", bus.illegal_o, 0);
        drive(7'b0100011, 3'b010, 1'b0, 32'h100, 32'h55, 32'h8, 32'h0);
        tick;
        chk("store_a", bus.ALU_RS1_o, 32'h100);
        chk("store_b", bus.ALU_RS2_o, 32'h8);
        drive(7'b1100111, 3'b000, 1'b0, 32'h77, 32'h0, 32'h10, 32'h200);
        tick;
        chk("jalr_a", bus.ALU_RS1_o, 32'h200);
        chk("jalr_b", bus.ALU_RS2_o, 32'h4);
        drive(7'h7F, 3'b000, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4);
        tick;
        chk("badopc_illegal", bus.illegal_o, 1);
        bus.valid_i = 1'b0;
        tick;
        chk("idle_valid", bus.valid_o, 0);

        // stall: AUIPC then JAL with ready_i low for three edges
        oq_a.delete();
        oq_b.delete();
        base = hs_cnt;
        bus.ready_i = 1'b0;
        drive(7'b0010111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h2000, 32'h100);
        tick;
        chk("stl_valid", bus.valid_o, 1);
        chk("stl_a", bus.ALU_RS1_o, 32'h100);
        chk("stl_b", bus.ALU_RS2_o, 32'h2000);
`ifdef ALU_ISSUE_SKID_EN
        chk("stl_ready1", bus.ready_o, 1);
`else
        chk("stl_ready1", bus.ready_o, 0);
`endif
        drive(7'b1101111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h40, 32'h104);
        tick;
        if (hs_cnt == base + 2) bus.valid_i = 1'b0;
        chk("stl_hold1_valid", bus.valid_o, 1);
        chk("stl_hold1_a", bus.ALU_RS1_o, 32'h100);
        chk("stl_hold1_b", bus.ALU_RS2_o, 32'h2000);
        chk("stl_ready2", bus.ready_o, 0);
        tick;
        if (hs_cnt == base + 2) bus.valid_i = 1'b0;
        chk("stl_hold2_a", bus.ALU_RS1_o, 32'h100);
        chk("stl_hold2_b", bus.ALU_RS2_o, 32'h2000);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 8 && (oq_a.size() < 2 || bus.valid_i); i++) begin
            tick;
            if (hs_cnt == base + 2) bus.valid_i = 1'b0;
        end
        chk("stl_accepts", hs_cnt - base, 2);
        chk("stl_count", oq_a.size(), 2);
        chk("stl_a0", oq_a[0], 32'h100);
        chk("stl_b0", oq_b[0], 32'h2000);
        chk("stl_a1", oq_a[1], 32'h104);
        chk("stl_b1", oq_b[1], 32'h4);
        chk("stl_drained", bus.valid_o, 0);

        // flush while an instruction is held and another is offered
        oq_a.delete();
        oq_b.delete();
        bus.ready_i = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h0, 32'h0, 32'h0);
        tick;
        chk("fl_pre_valid", bus.valid_o, 1);
        drive(7'b0110011, 3'b000, 1'b0, 32'h22, 32'h0, 32'h0, 32'h0);
        bus.flush_i = 1'b1;
        tick;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("fl_valid", bus.valid_o, 0);
        chk("fl_ready", bus.ready_o, 1);
        bus.ready_i = 1'b1;
        repeat (3) tick;
        chk("fl_still_empty", bus.valid_o, 0);
        chk("fl_none_out", oq_a.size(), 0);

        // asynchronous reset while holding an instruction
        bus.ready_i = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 32'h33, 32'h1, 32'h0, 32'h0);
        tick;
        chk("ar_pre_valid", bus.valid_o, 1);
        drive(7'b0110011, 3'b000, 1'b0, 32'h44, 32'h1, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.valid_o, 0);
        chk("ar_ready", bus.ready_o, 1);
        chk("ar_op", bus.ALU_OP_o, 0);
        chk("ar_a", bus.ALU_RS1_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        bus.valid_i = 1'b0;
        chk("ar_first_valid", bus.valid_o, 1);
        chk("ar_first_a", bus.ALU_RS1_o, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Registered issue stage directly upstream of the RV32I ALU in the execute path. Each cycle it accepts one decoded instruction over a valid/ready handshake and translates opcode/funct fields into the ALU's 4-bit operation code. It selects the ALU operands (register, immediate, PC, constant), flags branches and illegal encodings, and presents everything registered to the ALU and branch logic.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  upstream instruction valid.
- `ready_o`  out  1  stage can accept this cycle.
- `opcode_i`  in  7  instruction bits [6:0].
- `funct3_i`  in  3  instruction bits [14:12].
- `funct7b5_i`  in  1  instruction bit 30.
- `rs1_data_i`  in  XLEN  rs1 register value.
- `rs2_data_i`  in  XLEN  rs2 register value.
- `imm_i`  in  XLEN  sign-extended immediate, already formatted by the decoder.
- `pc_i`  in  XLEN  instruction PC.
- `flush_i`  in  1  kill all held and incoming instructions.
- `valid_o`  out  1  issued instruction valid.
- `ready_i`  in  1  downstream accepts this cycle.
- `ALU_OP_o`  out  4  ALU opcode.
- `ALU_RS1_o`  out  XLEN  ALU operand A.
- `ALU_RS2_o`  out  XLEN  ALU operand B.
- `branch_o`  out  1  instruction is a conditional branch.
- `br_inv_o`  out  1  branch is taken when the ALU result is 0 (BNE).
- `illegal_o`  out  1  unsupported opcode or funct.

## Operation
- Transfer occurs on any edge where valid and ready are both high. Data outputs are stable while `valid_o && !ready_i`.
- ALU codes used: AND 0000, OR 0001, SUM 0010, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111, SLL 0100, SRL 0101, SRA 0111, XOR 1000, EQUAL 0011.
- OP (0110011), A=rs1, B=rs2, decoded by funct3:
  - 000: SUM, or SUB when b5=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when b5=1.
  - 110: OR.
  - 111: AND.
- OP-IMM (0010011) uses the same map with A=rs1, B=imm, except funct3=000 is always SUM.
- For any shift, B is `{27'b0, B[4:0]}`. The ALU shifts by the full 32 bits, so the issue stage masks the amount.
- LUI (0110111): SUM, A=0, B=imm.
- AUIPC (0010111): SUM, A=pc, B=imm.
- JAL (1101111) and JALR (1100111): SUM, A=pc, B=4 (link value).
- LOAD (0000011) and STORE (0100011): SUM, A=rs1, B=imm.
- BRANCH (1100011): A=rs1, B=rs2, `branch_o`=1.
  - BEQ: EQUAL.
  - BNE: EQUAL with `br_inv_o`=1.
  - BLT: SLT.
  - BGE: GE.
  - BLTU: SLTU.
  - BGEU: GEU.
  - funct3 010 or 011 is illegal.
- Any other opcode, or a funct7 other than 0000000/0100000 where it applies, sets `illegal_o`=1 with op=AND and A=B=0. The instruction still issues.

## Timing
- Reset values: `valid_o`=0, `ready_o`=1; `ALU_OP_o`, operands, `branch_o`, `br_inv_o`, `illegal_o` all 0.
- Latency is one cycle from accept to `valid_o`. Throughput is one instruction per cycle.
- `flush_i`=1 at an edge:
  - `valid_o` is 0 after that edge and held entries are discarded.
  - An instruction handshaken in the same cycle is consumed and dropped.
  - Flush has priority over accept.
- Accept and downstream transfer in the same cycle: the new instruction replaces the old one with no bubble.
- Reset asserted mid-operation: all state returns to reset values immediately. The first accept is possible on the first edge after deassertion.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Two-entry skid buffer (main plus skid); `ready_o` is a registered signal equal to "skid entry empty".
  - If `ready_i`=0 while an instruction is accepted, the instruction goes to the skid entry and `ready_o` drops on the next cycle.
  - The skid entry drains to the main entry, in order, on the next downstream transfer.
  - No combinational path from `ready_i` to `ready_o`.
- Undefined:
  - Single register; `ready_o = !valid_o || ready_i` (combinational).
  - Reset value of `ready_o` is 1 in both builds.

## Test plan
- ADD, rs1=5, rs2=7, `ready_i`=1 -> next cycle `valid_o`=1, op=0010, A=5, B=7.
- SRAI, funct7b5=1, imm=0x0000_0423 -> op=0111, B=0x0000_0003.
- BNE, rs1=3, rs2=3 -> op=0011, `branch_o`=1, `br_inv_o`=1.
- BEQ, funct3 shifted to 010 -> `illegal_o`=1, op=0000, A=B=0.
- Back-to-back AUIPC (pc=0x100, imm=0x2000) then JAL (pc=0x104), with `ready_i` held 0 for 3 cycles:
  - Outputs are held stable.
  - Both builds: in-order delivery of A=0x100/B=0x2000, then A=0x104/B=4, with no loss or duplication.
  - Skid build: `ready_o` falls one cycle after the stall-accept.
- `flush_i` pulsed while `valid_o`=1 and an input is accepted -> `valid_o`=0 next cycle. Neither instruction ever appears.
